// File: rtl/wb_host_sequencer.sv
// Wishbone classic initiator: one bus cycle per valid/ready command,
// with a per-cycle ack timeout and a saturating abort counter.
module wb_host_sequencer #(
  parameter int TIMEOUT   = 255,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  // Counter holds the number of BUS cycles already elapsed
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (!(&err_count))
              err_count <= err_count + ERR_CNT_W'(1);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_sequencer.sv
// Randomized bench for wb_host_sequencer: transaction-level model
// of bus occupancy, response and counters, checked every cycle.
module tb_wb_host_sequencer;

  localparam int TO  = 4;
  localparam int EW  = 8;
  localparam int NOACK = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [31:0]   cmd_adr;
  logic [31:0]   cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic [EW-1:0] err_count;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic          wbm_ack_i;
  logic [31:0]   wbm_dat_i;

  wb_host_sequencer #(
    .TIMEOUT  (TO),
    .ERR_CNT_W(EW)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .err_count(err_count),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // slave environment: ack after cur_lat cycles of cyc
  logic [31:0] smem [16];
  int          cur_lat = 99;
  int          bus_cnt;
  logic        stray;

  assign wbm_ack_i = (wbm_cyc_o && wbm_stb_o && bus_cnt == cur_lat) || stray;
  assign wbm_dat_i = smem[{wbm_adr_o[10], wbm_adr_o[4:2]}];

  always @(posedge clk or posedge rst) begin
    if (rst)             bus_cnt <= 0;
    else if (!wbm_cyc_o) bus_cnt <= 0;
    else                 bus_cnt <= bus_cnt + 1;
  end

  // transaction-level model
  logic [31:0] mmem [16];
  int          bus_left;
  bit          resp_pend;
  bit          m_err;
  logic [31:0] e_dat;
  bit          e_err;
  int          e_cnt;
  bit          e_we;
  logic [31:0] e_adr;
  logic [31:0] e_wdat;
  logic [3:0]  e_sel;
  bit          acc;

  // driver intent
  bit          d_cv, d_we, d_rr;
  logic [31:0] d_adr, d_dat;
  logic [3:0]  d_sel;
  int          d_lat;
  bit          en_stray;

  // observations during one transaction
  int          cyc_seen;
  logic [31:0] got_dat;
  logic        got_err;

  function automatic int idx(input logic [31:0] a);
    return int'({a[10], a[4:2]});
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check();
    bit idle;
    idle = (bus_left == 0) && !resp_pend;
    cmp("cyc", 32'(wbm_cyc_o), 32'(bus_left > 0));
    cmp("stb", 32'(wbm_stb_o), 32'(bus_left > 0));
    cmp("cmd_ready", 32'(cmd_ready), 32'(idle));
    cmp("rsp_valid", 32'(rsp_valid), 32'(resp_pend));
    if (resp_pend) begin
      cmp("rsp_dat", rsp_dat, e_dat);
      cmp("rsp_err", 32'(rsp_err), 32'(e_err));
      got_dat = rsp_dat;
      got_err = rsp_err;
    end
    cmp("err_count", 32'(err_count), 32'(e_cnt));
    cmp("wbm_we", 32'(wbm_we_o), 32'(e_we));
    cmp("wbm_adr", wbm_adr_o, e_adr);
    cmp("wbm_dat", wbm_dat_o, e_wdat);
    cmp("wbm_sel", 32'(wbm_sel_o), 32'(e_sel));
    if (wbm_cyc_o) cyc_seen++;
  endtask

  task automatic put_bytes(inout logic [31:0] w, input logic [31:0] d,
                           input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
  endtask

  // predict what the next rising edge does
  task automatic model_edge();
    logic [31:0] w;
    if (bus_left > 0) begin
      bus_left--;
      if (bus_left == 0) begin
        resp_pend = 1;
        if (m_err) begin
          e_err = 1;
          e_dat = 0;
          if (e_cnt != (1 << EW) - 1) e_cnt++;
        end else begin
          e_err = 0;
          e_dat = e_we ? 32'd0 : mmem[idx(e_adr)];
          if (e_we) begin
            w = mmem[idx(e_adr)];
            put_bytes(w, e_wdat, e_sel);
            mmem[idx(e_adr)] = w;
          end
        end
      end
    end else if (resp_pend) begin
      if (d_rr) resp_pend = 0;
    end else if (d_cv) begin
      acc     = 1;
      e_we    = d_we;
      e_adr   = d_adr;
      e_wdat  = d_dat;
      e_sel   = d_sel;
      cur_lat = d_lat;
      m_err    = (d_lat + 1 > TO);
      bus_left = m_err ? TO : d_lat + 1;
    end
  endtask

  task automatic step();
    logic [31:0] w;
    @(negedge clk);
    check();
    cmd_valid = d_cv;
    cmd_we    = d_we;
    cmd_adr   = d_adr;
    cmd_dat   = d_dat;
    cmd_sel   = d_sel;
    rsp_ready = d_rr;
    stray = en_stray && (bus_left == 0) && ($urandom_range(3) == 0);
    // slave stores what the DUT actually presents on the ack edge
    if (bus_left == 1 && !m_err && wbm_we_o) begin
      w = smem[idx(wbm_adr_o)];
      put_bytes(w, wbm_dat_o, wbm_sel_o);
      smem[idx(wbm_adr_o)] = w;
    end
    model_edge();
  endtask

  task automatic xact(input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int lat, input int hold);
    int wcnt;
    cyc_seen = 0;
    got_dat  = 'x;
    got_err  = 1'bx;
    d_cv = 1; d_we = we; d_adr = adr; d_dat = dat; d_sel = sel;
    d_lat = lat;
    d_rr = $urandom_range(1);
    acc = 0;
    while (!acc) step();
    wcnt = 0;
    while (bus_left > 0 || resp_pend) begin
      d_cv  = $urandom_range(1);
      d_we  = $urandom_range(1);
      d_adr = $urandom;
      d_dat = $urandom;
      d_sel = 4'($urandom);
      if (resp_pend) begin
        d_rr = (wcnt >= hold);
        wcnt++;
      end else begin
        d_rr = $urandom_range(1);
      end
      step();
    end
    d_cv = 0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      smem[i] = 0;
      mmem[i] = 0;
    end
    smem[8] = 32'h1234_5678;
    mmem[8] = 32'h1234_5678;
    rst = 1; stray = 0; en_stray = 0;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 0;
    d_cv = 0; d_we = 0; d_adr = 0; d_dat = 0; d_sel = 0; d_rr = 0;
    d_lat = 0;
    bus_left = 0; resp_pend = 0; m_err = 0;
    e_dat = 0; e_err = 0; e_cnt = 0;
    e_we = 0; e_adr = 0; e_wdat = 0; e_sel = 0;
    #3;
    cmp("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cmp("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    cmp("rst_adr", wbm_adr_o, 32'd0);
    cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("rst_rsp_dat", rsp_dat, 32'd0);
    cmp("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 0;

    // write select, registered-ack slave
    xact(1, 32'h3000_0000, 32'h0000_0003, 4'hF, 1, 0);
    cmp("wr_cyc_len", 32'(cyc_seen), 32'd2);
    cmp("wr_rsp_err", 32'(got_err), 32'd0);
    cmp("wr_rsp_dat", got_dat, 32'd0);
    xact(0, 32'h3000_0000, 32'h0, 4'hF, 1, 0);
    cmp("rd_sel_byte", 32'(got_dat[7:0]), 32'h03);
    xact(0, 32'h3000_0400, 32'h0, 4'hF, 1, 0);
    cmp("rd_freq", got_dat, 32'h1234_5678);
    en_stray = 1;
    // unmapped: nobody acks
    xact(0, 32'h3000_0300, 32'h0, 4'hF, NOACK, 0);
    cmp("tmo_cyc_len", 32'(cyc_seen), 32'd4);
    cmp("tmo_rsp_err", 32'(got_err), 32'd1);
    cmp("tmo_rsp_dat", got_dat, 32'd0);
    cmp("tmo_err_count", 32'(err_count), 32'd1);
    // ack on the timeout edge wins
    xact(0, 32'h3000_0000, 32'h0, 4'hF, TO - 1, 0);
    cmp("tie_rsp_err", 32'(got_err), 32'd0);
    cmp("tie_rsp_dat", got_dat, 32'd3);
    cmp("tie_err_count", 32'(err_count), 32'd1);
    xact(0, 32'h3000_0400, 32'h0, 4'h1, 0, 0);
    cmp("zw_cyc_len", 32'(cyc_seen), 32'd1);
    xact(1, 32'h3000_0004, 32'hDEAD_BEEF, 4'h0, 2, 10);
    xact(0, 32'h3000_0004, 32'h0, 4'hF, 2, 10);
    cmp("sel0_rd", got_dat, 32'd0);

    // reset in the middle of a bus cycle
    d_cv = 1; d_we = 0; d_adr = 32'h3000_0000; d_dat = 0; d_sel = 4'hF;
    d_lat = NOACK; d_rr = 1;
    acc = 0;
    while (!acc) step();
    d_cv = 0;
    step();
    step();
    @(posedge clk);
    #2 rst = 1;
    #1;
    cmp("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    cmp("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
    cmp("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("mid_rst_err_count", 32'(err_count), 32'd0);
    bus_left = 0; resp_pend = 0; m_err = 0;
    e_dat = 0; e_err = 0; e_cnt = 0;
    e_we = 0; e_adr = 0; e_wdat = 0; e_sel = 0;
    @(posedge clk);
    #2 rst = 0;
    xact(0, 32'h3000_0000, 32'h0, 4'hF, 1, 0);
    cmp("post_rst_dat", got_dat, 32'd3);
    cmp("post_rst_err", 32'(got_err), 32'd0);

    // randomized traffic
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = 32'h3000_0000 | (32'($urandom_range(1)) << 10)
                        | (32'($urandom_range(7)) << 2);
      xact($urandom_range(1), a, $urandom, 4'($urandom),
           $urandom_range(6), $urandom_range(3));
      repeat ($urandom_range(2)) step();
    end

    // saturation of the abort counter
    for (int k = 0; k < 300; k++)
      xact(0, 32'h3000_0300, 32'h0, 4'hF, NOACK, 0);
    step();
    cmp("err_sat", 32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
